alarm_scheduler: RTL and testbench

ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

---
 rtl/alarm_scheduler_pkg.sv | 15 +
 rtl/alarm_scheduler_if.sv | 28 ++
 rtl/alarm_scheduler_channel.sv | 69 ++++++
 rtl/alarm_scheduler.sv | 79 +++++++
 tb/tb_alarm_scheduler.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alarm_scheduler_pkg.sv
// alarm_pkg: shared types and defaults for the alarm scheduler.
//   state_t - per-channel state (IDLE, ARMED, PENDING)
//   ts_t    - 64-bit timestamp of the free-running timer
package alarm_pkg;
    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_DELAY_W = 32;

    typedef logic [63:0] ts_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        PENDING = 2'd2
    } state_t;
endpackage

// File: rtl/alarm_scheduler_if.sv
// alarm_scheduler_if: arm/cancel request bus and interrupt handshake.
//   req_valid/req_delay/req_ready - per-channel arm handshake (packed delays)
//   cancel                        - per-channel disarm
//   irq/irq_id/irq_ack            - pending-alarm interrupt and acknowledge
//   master: requester side, slave: scheduler side.
interface alarm_scheduler_if #(
    parameter int NUM_CH  = alarm_pkg::DEF_NUM_CH,
    parameter int DELAY_W = alarm_pkg::DEF_DELAY_W
);
    localparam int ID_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]         req_valid;
    logic [NUM_CH*DELAY_W-1:0] req_delay;
    logic [NUM_CH-1:0]         req_ready;
    logic [NUM_CH-1:0]         cancel;
    logic                      irq;
    logic [ID_W-1:0]           irq_id;
    logic                      irq_ack;

    modport master (
        output req_valid, req_delay, cancel, irq_ack,
        input  req_ready, irq, irq_id
    );
    modport slave (
        input  req_valid, req_delay, cancel, irq_ack,
        output req_ready, irq, irq_id
    );
endinterface

// File: rtl/alarm_scheduler_channel.sv
// alarm_channel: one alarm channel - FSM, deadline register, wrap-safe
// expiry comparator and registered fire pulse.
//   clk, rst             - clock, synchronous active-high reset
//   t                    - current timer value
//   req_valid, req_delay - arm request and delay (cycles)
//   cancel, ack          - disarm / acknowledge of the pending alarm
//   req_ready            - channel can accept an arm request
//   armed, pending, fire - state flags and one-cycle expiry pulse
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int DELAY_W = DEF_DELAY_W
) (
    input  logic               clk,
    input  logic               rst,
    input  ts_t                t,
    input  logic               req_valid,
    input  logic [DELAY_W-1:0] req_delay,
    input  logic               cancel,
    input  logic               ack,
    output logic               req_ready,
    output logic               armed,
    output logic               pending,
    output logic               fire
);
    state_t state, state_nx;
    ts_t    deadline;
    ts_t    diff;
    logic   accept;
    logic   expired;
    logic   fire_q;

    // Sign of the modular difference keeps the compare correct across rollover.
    assign diff    = t - deadline;
    assign expired = (state == ARMED) && !diff[63];
    assign accept  = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            deadline <= '0;
            fire_q   <= 1'b0;
        end else begin
            state  <= state_nx;
            fire_q <= (state == ARMED) && (state_nx == PENDING);
            if (accept)
                deadline <= t + {{(64-DELAY_W){1'b0}}, req_delay};
        end
    end

    // Cancel takes priority over both expiry and acknowledge.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = ARMED;
            ARMED:   if (cancel) state_nx = IDLE;
                     else if (expired) state_nx = PENDING;
            PENDING: if (cancel || ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = !rst && (state == IDLE) && !cancel;
        armed     = (state == ARMED);
        pending   = (state == PENDING);
        fire      = fire_q && !rst;
    end
endmodule

// File: rtl/alarm_scheduler.sv
// alarm_scheduler: NUM_CH independent alarm channels plus a round-robin
// arbiter that presents one PENDING channel at a time on irq/irq_id.
//   clk, rst - clock, synchronous active-high reset
//   t        - free-running 64-bit timer value
//   bus      - request/cancel bus and irq handshake (slave side)
//   armed    - per-channel ARMED flag
//   fire     - per-channel one-cycle expiry pulse
module alarm_scheduler
    import alarm_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int DELAY_W = DEF_DELAY_W
) (
    input  logic              clk,
    input  logic              rst,
    input  ts_t               t,
    alarm_scheduler_if.slave  bus,
    output logic [NUM_CH-1:0] armed,
    output logic [NUM_CH-1:0] fire
);
    localparam int ID_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] ack;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   hold_id;
    logic [ID_W-1:0]   pick;
    logic              hold_vld;
    logic              ack_ok;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        alarm_channel #(.DELAY_W(DELAY_W)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .t         (t),
            .req_valid (bus.req_valid[i]),
            .req_delay (bus.req_delay[i*DELAY_W +: DELAY_W]),
            .cancel    (bus.cancel[i]),
            .ack       (ack[i]),
            .req_ready (bus.req_ready[i]),
            .armed     (armed[i]),
            .pending   (pending[i]),
            .fire      (fire[i])
        );
    end

    // First PENDING channel at or after ptr; scanning downward lets the
    // nearest one win. Yields 0 when nothing is pending.
    always_comb begin
        pick = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (pending[(int'(ptr) + k) % NUM_CH])
                pick = ID_W'((int'(ptr) + k) % NUM_CH);
        end
    end

    // Keep presenting the same channel while it remains PENDING.
    assign bus.irq    = |pending;
    assign bus.irq_id = (hold_vld && pending[hold_id]) ? hold_id : pick;
    assign ack_ok     = bus.irq_ack && bus.irq;

    always_comb begin
        ack = '0;
        if (ack_ok) ack[bus.irq_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            hold_id  <= '0;
            hold_vld <= 1'b0;
        end else begin
            hold_id  <= bus.irq_id;
            hold_vld <= bus.irq;
            if (ack_ok)
                ptr <= (bus.irq_id == ID_W'(NUM_CH - 1)) ? '0 : bus.irq_id + 1'b1;
        end
    end
endmodule

// File: tb/tb_alarm_scheduler.sv
// tb_alarm_scheduler: directed scenarios; expected fire pulses, irq ids and
// state snapshots are queued by the stimulus and checked by one monitor.
module tb_alarm_scheduler;
    import alarm_pkg::*;

    localparam int NUM_CH  = 4;
    localparam int DELAY_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    ts_t               t;
    logic              tld = 1'b0;
    ts_t               tval = '0;
    logic [NUM_CH-1:0] armed;
    logic [NUM_CH-1:0] fire;

    alarm_scheduler_if #(.NUM_CH(NUM_CH), .DELAY_W(DELAY_W)) bus ();

    alarm_scheduler #(.NUM_CH(NUM_CH), .DELAY_W(DELAY_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .t     (t),
        .bus   (bus),
        .armed (armed),
        .fire  (fire)
    );

    always #5 clk = ~clk;

    // Free-running timer with a load port for the rollover scenario.
    always @(posedge clk) begin
        if (rst)      t <= '0;
        else if (tld) t <= tval;
        else          t <= t + 64'd1;
    end

    typedef struct {
        ts_t               t;
        logic [NUM_CH-1:0] v;
    } fire_exp_t;

    typedef struct {
        int                tag;
        bit                bad;
        bit                cid;
        logic              irq;
        logic [1:0]        id;
        logic [NUM_CH-1:0] armed;
        logic [NUM_CH-1:0] ready;
    } snap_t;

    fire_exp_t  fire_q[$];
    logic [1:0] irq_q[$];
    snap_t      snap_q[$];
    int         n_vec = 0;
    int         n_miss = 0;
    bit         done = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input int tag, input logic irq, input logic [NUM_CH-1:0] a,
                        input logic [NUM_CH-1:0] r, input bit cid, input logic [1:0] id);
        snap_t s;
        s.tag = tag; s.bad = 1'b0; s.cid = cid; s.irq = irq;
        s.id = id; s.armed = a; s.ready = r;
        snap_q.push_back(s);
    endtask

    task automatic wait_t(input ts_t x);
        int n;
        snap_t s;
        n = 0;
        while (t != x && n < 300) begin
            step();
            n++;
        end
        if (t != x) begin
            s.tag = -1; s.bad = 1'b1; s.cid = 1'b0; s.irq = 1'b0;
            s.id = '0; s.armed = '0; s.ready = '0;
            snap_q.push_back(s);
        end
    endtask

    task automatic set_req(input int ch, input logic [DELAY_W-1:0] d);
        bus.req_valid[ch] = 1'b1;
        bus.req_delay[ch*DELAY_W +: DELAY_W] = d;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_delay = '0;
        bus.cancel    = '0;
        bus.irq_ack   = 1'b0;
        #20 rst = 1'b0;
        step();
        snap(0, 1'b0, 4'b0000, 4'b1111, 1'b1, 2'd0);

        // Single alarm, delay 5 accepted at t=3.
        wait_t(3);
        set_req(0, 32'd5);
        step();
        bus.req_valid = '0;
        fire_q.push_back('{t: 64'd9, v: 4'b0001});
        irq_q.push_back(2'd0);
        wait_t(9);
        bus.irq_ack = 1'b1;
        snap(1, 1'b1, 4'b0000, 4'b1110, 1'b1, 2'd0);
        step();
        bus.irq_ack = 1'b0;
        snap(2, 1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0);

        // Two channels expiring together, acked in round-robin order.
        wait_t(12);
        set_req(1, 32'd4);
        set_req(3, 32'd4);
        step();
        bus.req_valid = '0;
        fire_q.push_back('{t: 64'd17, v: 4'b1010});
        irq_q.push_back(2'd1);
        irq_q.push_back(2'd3);
        wait_t(17);
        bus.irq_ack = 1'b1;
        snap(3, 1'b1, 4'b0000, 4'b0101, 1'b1, 2'd1);
        step();
        snap(4, 1'b1, 4'b0000, 4'b0111, 1'b1, 2'd3);
        step();
        bus.irq_ack = 1'b0;
        snap(5, 1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0);

        // Re-request while armed must not move the deadline; cancel on expiry.
        wait_t(22);
        set_req(2, 32'd10);
        step();
        bus.req_valid = '0;
        wait_t(25);
        set_req(2, 32'd1);
        step();
        bus.req_valid = '0;
        snap(6, 1'b0, 4'b0100, 4'b1011, 1'b0, 2'd0);
        wait_t(32);
        bus.cancel[2] = 1'b1;
        snap(7, 1'b0, 4'b0100, 4'b1011, 1'b0, 2'd0);
        step();
        bus.cancel = '0;
        snap(8, 1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0);
        wait_t(36);

        // Deadline across the 2^64 rollover.
        tld  = 1'b1;
        tval = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        tld = 1'b0;
        set_req(0, 32'd3);
        step();
        bus.req_valid = '0;
        fire_q.push_back('{t: 64'd2, v: 4'b0001});
        irq_q.push_back(2'd0);
        wait_t(1);
        snap(9, 1'b0, 4'b0001, 4'b1110, 1'b0, 2'd0);
        wait_t(2);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        snap(10, 1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0);

        // Reset one cycle before expiry discards alarms; then delay 0.
        wait_t(5);
        set_req(0, 32'd6);
        set_req(1, 32'd6);
        step();
        bus.req_valid = '0;
        wait_t(10);
        rst = 1'b1;
        snap(11, 1'b0, 4'b0011, 4'b0000, 1'b0, 2'd0);
        step();
        rst = 1'b0;
        snap(12, 1'b0, 4'b0000, 4'b1111, 1'b1, 2'd0);
        wait_t(2);
        set_req(0, 32'd0);
        step();
        bus.req_valid = '0;
        fire_q.push_back('{t: 64'd4, v: 4'b0001});
        irq_q.push_back(2'd0);
        wait_t(4);
        bus.irq_ack = 1'b1;
        snap(13, 1'b1, 4'b0000, 4'b1110, 1'b1, 2'd0);
        step();
        bus.irq_ack = 1'b0;
        snap(14, 1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0);
        wait_t(8);
        done = 1'b1;
    end

    fire_exp_t  m_f;
    snap_t      m_s;
    logic [1:0] m_id;
    logic       prev_irq = 1'b0;
    logic [1:0] prev_id = '0;

    always @(negedge clk) begin
        if (fire != '0) begin
            n_vec++;
            if (fire_q.size() == 0) begin
                n_miss++;
                $display("FAIL fire: got %b at t=%0d, none expected", fire, t);
            end else begin
                m_f = fire_q.pop_front();
                if (fire !== m_f.v || t !== m_f.t) begin
                    n_miss++;
                    $display("FAIL fire: got %b at t=%0d, want %b at t=%0d", fire, t, m_f.v, m_f.t);
                end
            end
        end

        if (bus.irq === 1'b1 && (!prev_irq || bus.irq_id != prev_id)) begin
            n_vec++;
            if (irq_q.size() == 0) begin
                n_miss++;
                $display("FAIL irq_id: got %0d at t=%0d, none expected", bus.irq_id, t);
            end else begin
                m_id = irq_q.pop_front();
                if (bus.irq_id !== m_id) begin
                    n_miss++;
                    $display("FAIL irq_id: got %0d at t=%0d, want %0d", bus.irq_id, t, m_id);
                end
            end
        end
        prev_irq = (bus.irq === 1'b1);
        prev_id  = bus.irq_id;

        while (snap_q.size() > 0) begin
            m_s = snap_q.pop_front();
            n_vec++;
            if (m_s.bad) begin
                n_miss++;
                $display("FAIL timeout: timer target not reached, t=%0d", t);
            end else if (bus.irq !== m_s.irq || armed !== m_s.armed ||
                         bus.req_ready !== m_s.ready || (m_s.cid && bus.irq_id !== m_s.id)) begin
                n_miss++;
                $display("FAIL snap%0d: t=%0d got irq=%b id=%0d armed=%b ready=%b, want irq=%b id=%0d armed=%b ready=%b",
                         m_s.tag, t, bus.irq, bus.irq_id, armed, bus.req_ready,
                         m_s.irq, m_s.id, m_s.armed, m_s.ready);
            end
        end

        if (done) begin
            while (fire_q.size() > 0) begin
                m_f = fire_q.pop_front();
                n_vec++;
                n_miss++;
                $display("FAIL fire: got none, want %b at t=%0d", m_f.v, m_f.t);
            end
            while (irq_q.size() > 0) begin
                m_id = irq_q.pop_front();
                n_vec++;
                n_miss++;
                $display("FAIL irq_id: got none, want %0d", m_id);
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
